// File: rtl/dram_cmd_responder.sv
// DRAM command responder: per-bank timing FSMs, one-deep burst tracker and refresh busy window.
// Optional macro DRAM_RESP_CHECK_EN compiles the err/err_code reporting registers.
module dram_cmd_responder #(
    parameter int tRCD = 4,
    parameter int tRP  = 4,
    parameter int tCL  = 5,
    parameter int tCWL = 4,
    parameter int tRFC = 16,
    parameter int BL   = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [2:0]  cmd,
    input  logic [1:0]  bg,
    input  logic [1:0]  bank,
    input  logic [14:0] row,
    input  logic [9:0]  col,
    output logic        rd_en_dq,
    output logic        wr_en_dq,
    output logic [3:0]  dq_bank,
    output logic [14:0] dq_row,
    output logic [9:0]  dq_col,
    output logic [15:0] bank_open,
    output logic        busy,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam logic [2:0] CMD_NOP  = 3'b000;
    localparam logic [2:0] CMD_ACT  = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [2:0] CMD_WR   = 3'b011;
    localparam logic [2:0] CMD_PRE  = 3'b100;
    localparam logic [2:0] CMD_PREA = 3'b101;
    localparam logic [2:0] CMD_REF  = 3'b110;
    localparam logic [2:0] CMD_RSV  = 3'b111;

    // Counters are loaded with (param - 1) so a parameter of 1 skips the transient state.
    localparam logic [5:0] TRCD_M1  = 6'(tRCD - 1);
    localparam logic [5:0] TRP_M1   = 6'(tRP - 1);
    localparam logic [5:0] TCL_M1   = 6'(tCL - 1);
    localparam logic [5:0] TCWL_M1  = 6'(tCWL - 1);
    localparam logic [5:0] TRFC_M1  = 6'(tRFC - 1);
    localparam logic [5:0] BL_M1    = 6'(BL - 1);
    localparam logic [9:0] COL_MASK = 10'((1 << $clog2(BL)) - 1);

    typedef enum logic [1:0] {B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING} bank_state_t;
    typedef enum logic [1:0] {T_IDLE, T_WAIT, T_BURST} trk_state_t;

    bank_state_t bank_state_r [16];
    bank_state_t bank_state_s [16];
    logic [5:0]  bank_cnt_r   [16];
    logic [5:0]  bank_cnt_s   [16];
    logic [14:0] bank_row_r   [16];
    logic [14:0] bank_row_s   [16];
    logic [15:0] bank_open_r;

    trk_state_t  trk_state_r;
    logic        trk_rd_r;
    logic [5:0]  trk_cnt_r;
    logic [5:0]  beat_r;
    logic [3:0]  trk_bank_r;
    logic [14:0] trk_row_r;
    logic [9:0]  trk_col_r;
    logic        rd_en_r;
    logic        wr_en_r;
    logic [3:0]  dq_bank_r;
    logic [14:0] dq_row_r;
    logic [9:0]  dq_col_r;

    logic [5:0]  ref_cnt_r;
    logic        busy_r;

    logic [3:0]  idx_s;
    logic        all_idle_s;
    logic [2:0]  chk_code_s;
    logic        act_ok_s;
    logic        rdwr_ok_s;
    logic        pre_ok_s;
    logic        prea_ok_s;
    logic        ref_ok_s;
    logic [5:0]  lat_s;

    // Column for a given beat: the low log2(BL) bits wrap inside the burst.
    function automatic logic [9:0] beat_col(input logic [9:0] base, input logic [5:0] beat);
        logic [9:0] sum;
        sum = base + {4'd0, beat};
        return (base & ~COL_MASK) | (sum & COL_MASK);
    endfunction

    assign idx_s = {bg, bank};
    assign lat_s = (cmd == CMD_RD) ? TCL_M1 : TCWL_M1;

    // All-banks-idle detection for REF legality.
    always_comb begin
        all_idle_s = 1'b1;
        for (int i = 0; i < 16; i++) begin
            all_idle_s = all_idle_s & (bank_state_r[i] == B_IDLE);
        end
    end

    // Command legality; a nonzero code means the command is ignored.
    always_comb begin
        chk_code_s = 3'd0;
        if (cmd == CMD_NOP) begin
            chk_code_s = 3'd0;
        end else if (busy_r || (cmd == CMD_RSV)) begin
            chk_code_s = 3'd6;
        end else begin
            case (cmd)
                CMD_ACT: chk_code_s = (bank_state_r[idx_s] != B_IDLE) ? 3'd1 : 3'd0;
                CMD_RD, CMD_WR: begin
                    if (bank_state_r[idx_s] != B_ACTIVE) begin
                        chk_code_s = 3'd2;
                    end else if (trk_state_r != T_IDLE) begin
                        chk_code_s = 3'd5;
                    end else begin
                        chk_code_s = 3'd0;
                    end
                end
                CMD_PRE: chk_code_s = ((bank_state_r[idx_s] == B_ACTIVATING) ||
                                       (bank_state_r[idx_s] == B_PRECHARGING)) ? 3'd3 : 3'd0;
                CMD_REF: chk_code_s = all_idle_s ? 3'd0 : 3'd4;
                default: chk_code_s = 3'd0;
            endcase
        end
    end

    assign act_ok_s  = (cmd == CMD_ACT)  && (chk_code_s == 3'd0);
    assign rdwr_ok_s = ((cmd == CMD_RD) || (cmd == CMD_WR)) && (chk_code_s == 3'd0);
    assign pre_ok_s  = (cmd == CMD_PRE)  && (chk_code_s == 3'd0);
    assign prea_ok_s = (cmd == CMD_PREA) && (chk_code_s == 3'd0);
    assign ref_ok_s  = (cmd == CMD_REF)  && (chk_code_s == 3'd0);

    // Per-bank next state; counters only decrement above 1, so they never wrap.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            bank_state_s[i] = bank_state_r[i];
            bank_cnt_s[i]   = bank_cnt_r[i];
            bank_row_s[i]   = bank_row_r[i];
            case (bank_state_r[i])
                B_IDLE: begin
                    if (act_ok_s && (idx_s == 4'(i))) begin
                        bank_state_s[i] = (TRCD_M1 == 6'd0) ? B_ACTIVE : B_ACTIVATING;
                        bank_cnt_s[i]   = TRCD_M1;
                        bank_row_s[i]   = row;
                    end else begin
                        bank_cnt_s[i] = 6'd0;
                    end
                end
                B_ACTIVATING: begin
                    if (bank_cnt_r[i] <= 6'd1) begin
                        bank_state_s[i] = B_ACTIVE;
                        bank_cnt_s[i]   = 6'd0;
                    end else begin
                        bank_cnt_s[i] = bank_cnt_r[i] - 6'd1;
                    end
                end
                B_ACTIVE: begin
                    if ((pre_ok_s && (idx_s == 4'(i))) || prea_ok_s) begin
                        bank_state_s[i] = (TRP_M1 == 6'd0) ? B_IDLE : B_PRECHARGING;
                        bank_cnt_s[i]   = TRP_M1;
                    end else begin
                        bank_cnt_s[i] = 6'd0;
                    end
                end
                B_PRECHARGING: begin
                    if (bank_cnt_r[i] <= 6'd1) begin
                        bank_state_s[i] = B_IDLE;
                        bank_cnt_s[i]   = 6'd0;
                    end else begin
                        bank_cnt_s[i] = bank_cnt_r[i] - 6'd1;
                    end
                end
                default: begin
                    bank_state_s[i] = B_IDLE;
                    bank_cnt_s[i]   = 6'd0;
                end
            endcase
        end
    end

    // Bank state registers and the registered bank_open map.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 16; i++) begin
                bank_state_r[i] <= B_IDLE;
                bank_cnt_r[i]   <= 6'd0;
                bank_row_r[i]   <= 15'd0;
            end
            bank_open_r <= 16'd0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                bank_state_r[i] <= bank_state_s[i];
                bank_cnt_r[i]   <= bank_cnt_s[i];
                bank_row_r[i]   <= bank_row_s[i];
                bank_open_r[i]  <= (bank_state_s[i] == B_ACTIVE);
            end
        end
    end

    // Refresh window: busy covers the tRFC-1 cycles after an accepted REF.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ref_cnt_r <= 6'd0;
            busy_r    <= 1'b0;
        end else if (ref_ok_s) begin
            ref_cnt_r <= TRFC_M1;
            busy_r    <= (TRFC_M1 != 6'd0);
        end else if (ref_cnt_r != 6'd0) begin
            ref_cnt_r <= ref_cnt_r - 6'd1;
            busy_r    <= (ref_cnt_r > 6'd1);
        end else begin
            busy_r <= 1'b0;
        end
    end

    // Burst tracker FSM: latency wait, then BL beats with registered strobes and address.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            trk_state_r <= T_IDLE;
            trk_rd_r    <= 1'b0;
            trk_cnt_r   <= 6'd0;
            beat_r      <= 6'd0;
            trk_bank_r  <= 4'd0;
            trk_row_r   <= 15'd0;
            trk_col_r   <= 10'd0;
            rd_en_r     <= 1'b0;
            wr_en_r     <= 1'b0;
            dq_bank_r   <= 4'd0;
            dq_row_r    <= 15'd0;
            dq_col_r    <= 10'd0;
        end else begin
            case (trk_state_r)
                T_IDLE: begin
                    if (rdwr_ok_s) begin
                        trk_rd_r   <= (cmd == CMD_RD);
                        trk_bank_r <= idx_s;
                        trk_row_r  <= bank_row_r[idx_s];
                        trk_col_r  <= col;
                        beat_r     <= 6'd0;
                        if (lat_s == 6'd0) begin
                            trk_state_r <= T_BURST;
                            rd_en_r     <= (cmd == CMD_RD);
                            wr_en_r     <= (cmd == CMD_WR);
                            dq_bank_r   <= idx_s;
                            dq_row_r    <= bank_row_r[idx_s];
                            dq_col_r    <= col;
                        end else begin
                            trk_state_r <= T_WAIT;
                            trk_cnt_r   <= lat_s;
                        end
                    end else begin
                        rd_en_r <= 1'b0;
                        wr_en_r <= 1'b0;
                    end
                end
                T_WAIT: begin
                    if (trk_cnt_r <= 6'd1) begin
                        trk_state_r <= T_BURST;
                        trk_cnt_r   <= 6'd0;
                        rd_en_r     <= trk_rd_r;
                        wr_en_r     <= ~trk_rd_r;
                        dq_bank_r   <= trk_bank_r;
                        dq_row_r    <= trk_row_r;
                        dq_col_r    <= trk_col_r;
                    end else begin
                        trk_cnt_r <= trk_cnt_r - 6'd1;
                    end
                end
                T_BURST: begin
                    if (beat_r >= BL_M1) begin
                        trk_state_r <= T_IDLE;
                        rd_en_r     <= 1'b0;
                        wr_en_r     <= 1'b0;
                    end else begin
                        beat_r   <= beat_r + 6'd1;
                        dq_col_r <= beat_col(trk_col_r, beat_r + 6'd1);
                    end
                end
                default: begin
                    trk_state_r <= T_IDLE;
                    rd_en_r     <= 1'b0;
                    wr_en_r     <= 1'b0;
                end
            endcase
        end
    end

`ifdef DRAM_RESP_CHECK_EN
    logic       err_r;
    logic [2:0] err_code_r;

    // Error pulse one cycle after the illegal command; the code is sticky.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_r      <= 1'b0;
            err_code_r <= 3'd0;
        end else begin
            err_r <= (chk_code_s != 3'd0);
            if (chk_code_s != 3'd0) begin
                err_code_r <= chk_code_s;
            end else begin
                err_code_r <= err_code_r;
            end
        end
    end

    assign err      = err_r;
    assign err_code = err_code_r;
`else
    assign err      = 1'b0;
    assign err_code = 3'd0;
`endif

    assign rd_en_dq  = rd_en_r;
    assign wr_en_dq  = wr_en_r;
    assign dq_bank   = dq_bank_r;
    assign dq_row    = dq_row_r;
    assign dq_col    = dq_col_r;
    assign bank_open = bank_open_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Bench for dram_cmd_responder: command table plus hand sequences, beats checked via a scoreboard queue.
module tb_dram_cmd_responder;

    localparam int T_RCD = 4;
    localparam int T_RP  = 4;
    localparam int T_CL  = 5;
    localparam int T_CWL = 4;
    localparam int T_RFC = 16;
    localparam int N_BL  = 4;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] ACT  = 3'b001;
    localparam logic [2:0] RD   = 3'b010;
    localparam logic [2:0] WR   = 3'b011;
    localparam logic [2:0] PRE  = 3'b100;
    localparam logic [2:0] PREA = 3'b101;
    localparam logic [2:0] REFR = 3'b110;
    localparam logic [2:0] RSV  = 3'b111;

    logic        CLK;
    logic        nRST;
    logic [2:0]  cmd;
    logic [1:0]  bg;
    logic [1:0]  bank;
    logic [14:0] row;
    logic [9:0]  col;
    logic        rd_en_dq;
    logic        wr_en_dq;
    logic [3:0]  dq_bank;
    logic [14:0] dq_row;
    logic [9:0]  dq_col;
    logic [15:0] bank_open;
    logic        busy;
    logic        err;
    logic [2:0]  err_code;

    typedef struct {
        int          cyc;
        logic        rd;
        logic [3:0]  bnk;
        logic [14:0] row;
        logic [9:0]  col;
    } beat_t;

    typedef struct {
        logic [2:0]  cmd;
        logic [1:0]  bg;
        logic [1:0]  bk;
        logic [14:0] row;
        logic [9:0]  col;
        logic [2:0]  code;
        logic [14:0] erow;
    } vec_t;

    beat_t q[$];
    beat_t mon_e;
    vec_t  vecs[32];
    int    cyc;
    int    n_chk;
    int    n_fail;

    dram_cmd_responder #(
        .tRCD(T_RCD), .tRP(T_RP), .tCL(T_CL), .tCWL(T_CWL), .tRFC(T_RFC), .BL(N_BL)
    ) dut (
        .CLK(CLK), .nRST(nRST), .cmd(cmd), .bg(bg), .bank(bank), .row(row), .col(col),
        .rd_en_dq(rd_en_dq), .wr_en_dq(wr_en_dq), .dq_bank(dq_bank), .dq_row(dq_row),
        .dq_col(dq_col), .bank_open(bank_open), .busy(busy), .err(err), .err_code(err_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] c, input logic [1:0] g, input logic [1:0] b,
                                input logic [14:0] r, input logic [9:0] co,
                                input logic [2:0] code, input logic [14:0] erow);
        vec_t v;
        v.cmd = c; v.bg = g; v.bk = b; v.row = r; v.col = co; v.code = code; v.erow = erow;
        return v;
    endfunction

    // Drive one command for one cycle; accepted RD/WR queue their expected beats.
    task automatic issue(input logic [2:0] c, input logic [1:0] g, input logic [1:0] b,
                         input logic [14:0] r, input logic [9:0] co,
                         input logic [2:0] exp_code, input logic [14:0] exp_row,
                         input string name);
        int    lat;
        beat_t e;
        logic [1:0] lo;
        cmd = c; bg = g; bank = b; row = r; col = co;
        if ((exp_code == 3'd0) && ((c == RD) || (c == WR))) begin
            lat = (c == RD) ? T_CL : T_CWL;
            for (int k = 0; k < N_BL; k++) begin
                lo    = co[1:0] + 2'(k);
                e.cyc = cyc + lat + k;
                e.rd  = (c == RD);
                e.bnk = {g, b};
                e.row = exp_row;
                e.col = {co[9:2], lo};
                q.push_back(e);
            end
        end
        @(posedge CLK);
        #1;
`ifdef DRAM_RESP_CHECK_EN
        chk({name, " err"}, {31'd0, err}, {31'd0, exp_code != 3'd0});
        if (exp_code != 3'd0) chk({name, " err_code"}, {29'd0, err_code}, {29'd0, exp_code});
`else
        chk({name, " err"}, {31'd0, err}, 32'd0);
        chk({name, " err_code"}, {29'd0, err_code}, 32'd0);
`endif
        cmd = NOP; bg = 2'd0; bank = 2'd0; row = 15'd0; col = 10'd0;
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) issue(NOP, 2'd0, 2'd0, 15'd0, 10'd0, 3'd0, 15'd0, "nop");
    endtask

    // Scoreboard: every strobe must match the oldest expected beat, on its cycle.
    always @(negedge CLK) begin
        if (nRST) begin
            if (rd_en_dq || wr_en_dq) begin
                if (q.size() == 0) begin
                    chk("beat without expectation", {30'd0, rd_en_dq, wr_en_dq}, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("beat cycle", cyc, mon_e.cyc);
                    chk("beat strobes", {30'd0, rd_en_dq, wr_en_dq},
                        mon_e.rd ? 32'd2 : 32'd1);
                    chk("dq_bank", {28'd0, dq_bank}, {28'd0, mon_e.bnk});
                    chk("dq_row", {17'd0, dq_row}, {17'd0, mon_e.row});
                    chk("dq_col", {22'd0, dq_col}, {22'd0, mon_e.col});
                end
            end else if ((q.size() > 0) && (q[0].cyc <= cyc)) begin
                mon_e = q.pop_front();
                chk("missing beat strobes", {30'd0, rd_en_dq, wr_en_dq},
                    mon_e.rd ? 32'd2 : 32'd1);
            end
        end
    end

    initial begin
        int r0;
        n_chk = 0;
        n_fail = 0;
        nRST = 1'b0;
        cmd = NOP; bg = 2'd0; bank = 2'd0; row = 15'd0; col = 10'd0;

        // Relative cycle i of the table; codes/rows follow the default timing parameters.
        for (int i = 0; i < 32; i++) vecs[i] = mk(NOP, 2'd0, 2'd0, 15'd0, 10'd0, 3'd0, 15'd0);
        vecs[0]  = mk(ACT,  2'd0, 2'd1, 15'h0123, 10'd0,    3'd0, 15'd0);
        vecs[3]  = mk(RD,   2'd0, 2'd1, 15'd0,    10'h010,  3'd2, 15'd0);
        vecs[4]  = mk(RD,   2'd0, 2'd1, 15'd0,    10'h010,  3'd0, 15'h0123);
        vecs[5]  = mk(ACT,  2'd0, 2'd1, 15'h0001, 10'd0,    3'd1, 15'd0);
        vecs[6]  = mk(ACT,  2'd2, 2'd3, 15'h7FFF, 10'd0,    3'd0, 15'd0);
        vecs[7]  = mk(RD,   2'd0, 2'd1, 15'd0,    10'h020,  3'd5, 15'd0);
        vecs[8]  = mk(PRE,  2'd2, 2'd3, 15'd0,    10'd0,    3'd3, 15'd0);
        vecs[9]  = mk(REFR, 2'd0, 2'd0, 15'd0,    10'd0,    3'd4, 15'd0);
        vecs[12] = mk(WR,   2'd2, 2'd3, 15'd0,    10'h3FE,  3'd5, 15'd0);
        vecs[13] = mk(WR,   2'd2, 2'd3, 15'd0,    10'h3FE,  3'd0, 15'h7FFF);
        vecs[14] = mk(RD,   2'd0, 2'd1, 15'd0,    10'h000,  3'd5, 15'd0);
        vecs[15] = mk(RSV,  2'd0, 2'd0, 15'd0,    10'd0,    3'd6, 15'd0);
        vecs[16] = mk(PRE,  2'd0, 2'd1, 15'd0,    10'd0,    3'd0, 15'd0);
        vecs[17] = mk(PRE,  2'd0, 2'd1, 15'd0,    10'd0,    3'd3, 15'd0);
        vecs[18] = mk(RD,   2'd0, 2'd1, 15'd0,    10'd0,    3'd2, 15'd0);
        vecs[19] = mk(PRE,  2'd1, 2'd0, 15'd0,    10'd0,    3'd0, 15'd0);
        vecs[20] = mk(ACT,  2'd0, 2'd1, 15'h00AA, 10'd0,    3'd0, 15'd0);
        vecs[21] = mk(RD,   2'd2, 2'd3, 15'd0,    10'h000,  3'd0, 15'h7FFF);

        repeat (3) @(posedge CLK);
        #1;
        chk("reset rd_en_dq", {31'd0, rd_en_dq}, 32'd0);
        chk("reset wr_en_dq", {31'd0, wr_en_dq}, 32'd0);
        chk("reset dq_bank", {28'd0, dq_bank}, 32'd0);
        chk("reset dq_row", {17'd0, dq_row}, 32'd0);
        chk("reset dq_col", {22'd0, dq_col}, 32'd0);
        chk("reset bank_open", {16'd0, bank_open}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset err_code", {29'd0, err_code}, 32'd0);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 32; i++) begin
            issue(vecs[i].cmd, vecs[i].bg, vecs[i].bk, vecs[i].row, vecs[i].col,
                  vecs[i].code, vecs[i].erow, $sformatf("vec%0d", i));
        end
        chk("bank_open after table", {16'd0, bank_open}, 32'h0802);

        // PREA closes both banks; REF while precharging is rejected, then accepted.
        issue(PREA, 2'd0, 2'd0, 15'd0, 10'd0, 3'd0, 15'd0, "prea");
        chk("bank_open after prea", {16'd0, bank_open}, 32'd0);
        nops(2);
        issue(REFR, 2'd0, 2'd0, 15'd0, 10'd0, 3'd4, 15'd0, "ref while precharging");
        r0 = cyc;
        issue(REFR, 2'd0, 2'd0, 15'd0, 10'd0, 3'd0, 15'd0, "ref accepted");
        chk("busy at ref+1", {31'd0, busy}, 32'd1);
        for (int j = 1; j < T_RFC; j++) begin
            if (j == 8) issue(ACT, 2'd1, 2'd1, 15'h0055, 10'd0, 3'd6, 15'd0, "act while busy");
            else        issue(NOP, 2'd0, 2'd0, 15'd0, 10'd0, 3'd0, 15'd0, "nop while busy");
            chk($sformatf("busy at ref+%0d", cyc - r0), {31'd0, busy},
                {31'd0, (j + 1) < T_RFC});
        end
        issue(ACT, 2'd1, 2'd1, 15'h0055, 10'd0, 3'd0, 15'd0, "act after refresh");
        nops(2);
        chk("bank_open at act+3", {16'd0, bank_open}, 32'd0);
        nops(1);
        chk("bank_open at act+4", {16'd0, bank_open}, 32'h0020);

        // Reset during a burst: beats at t+9, t+10 only, then everything cleared.
        issue(ACT, 2'd0, 2'd1, 15'h0123, 10'd0, 3'd0, 15'd0, "act before reset");
        nops(3);
        issue(RD, 2'd0, 2'd1, 15'd0, 10'h010, 3'd0, 15'h0123, "rd before reset");
        nops(6);
        nRST = 1'b0;
        q.delete();
        #1;
        chk("mid-burst reset rd_en_dq", {31'd0, rd_en_dq}, 32'd0);
        chk("mid-burst reset dq_col", {22'd0, dq_col}, 32'd0);
        chk("mid-burst reset dq_row", {17'd0, dq_row}, 32'd0);
        chk("mid-burst reset bank_open", {16'd0, bank_open}, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        nops(6);
        issue(RD, 2'd0, 2'd1, 15'd0, 10'h010, 3'd2, 15'd0, "rd after reset");
        issue(REFR, 2'd0, 2'd0, 15'd0, 10'd0, 3'd0, 15'd0, "ref after reset");
        chk("busy after reset ref", {31'd0, busy}, 32'd1);
        nops(20);
        chk("scoreboard drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_cmd_responder.md
DRAM_CMD_RESPONDER -- requirements
Module: dram_cmd_responder

Interface
REQ-001 Parameters (name, default, meaning): tRCD 4 ACT-to-RD/WR cycles; tRP 4 PRE-to-idle cycles; tCL 5 RD-to-first-read-beat cycles; tCWL 4 WR-to-first-write-beat cycles; tRFC 16 REF busy cycles; BL 4 beats per burst. Each is 1..63.
REQ-002 Ports (name, direction, width, meaning):
- CLK in 1: single clock.
- nRST in 1: asynchronous, active-low reset.
- cmd in 3: 000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE, 101 PREA, 110 REF, 111 reserved.
- bg in 2: bank group. bank in 2: bank. row in 15: ACT row. col in 10: RD/WR column.
- rd_en_dq out 1: read data beat strobe.
- wr_en_dq out 1: write data capture strobe.
- dq_bank out 4: {bg,bank} of the active burst.
- dq_row out 15: row of the active burst.
- dq_col out 10: column plus beat index.
- bank_open out 16: bit {bg,bank} set when that bank is ACTIVE.
- busy out 1: refresh in progress.
- err out 1: one-cycle illegal-command pulse.
- err_code out 3: code of the last error.

Function
REQ-003 SHALL keep one state per bank: IDLE, ACTIVATING, ACTIVE, PRECHARGING, each with a 6-bit down-counter and a 15-bit open-row register.
REQ-004 ACT at cycle t to an IDLE bank: bank goes ACTIVATING and latches row. Bank is ACTIVE from cycle t+tRCD, so RD/WR at t+tRCD is legal and at t+tRCD-1 is illegal.
REQ-005 PRE at cycle t to an ACTIVE bank: bank goes PRECHARGING and is IDLE from t+tRP. PRE to an IDLE bank is a legal no-op.
REQ-006 PREA SHALL apply REQ-005 to every ACTIVE bank in the same cycle.
REQ-007 REF at cycle t with all banks IDLE: busy=1 from t+1 through t+tRFC-1. Commands are accepted again at t+tRFC. Any non-NOP command while busy is illegal.
REQ-008 RD at cycle t to an ACTIVE bank with the burst tracker idle: rd_en_dq=1 for cycles t+tCL .. t+tCL+BL-1.
- dq_bank and dq_row come from the addressed bank.
- dq_col = col+beat; the low log2(BL) bits wrap within the burst.
REQ-009 WR SHALL behave as REQ-008 with tCWL and wr_en_dq.
REQ-010 The burst tracker SHALL hold one burst. It is idle again in the cycle after the last beat; a RD/WR in that cycle is legal.
REQ-011 Illegal commands SHALL cause no state change. Error codes:
- 1: ACT to a non-IDLE bank.
- 2: RD/WR to a non-ACTIVE bank.
- 3: PRE to an ACTIVATING or PRECHARGING bank.
- 4: REF with any bank non-IDLE.
- 5: RD/WR while the burst tracker is busy.
- 6: reserved cmd, or any command while busy.
REQ-012 err SHALL pulse in cycle t+1 for an illegal command at t; err_code updates in the same cycle and holds until the next error.
REQ-013 Counters SHALL saturate at 0 and never wrap. A parameter value of 1 SHALL give a one-cycle transition.
REQ-014 bank_open, busy, and the strobes SHALL be registered outputs.

Reset
REQ-015 nRST low SHALL asynchronously force:
- all banks IDLE; counters and row registers 0;
- tracker idle;
- rd_en_dq=0, wr_en_dq=0, dq_bank/dq_row/dq_col=0;
- bank_open=0, busy=0, err=0, err_code=0.
REQ-016 Reset asserted mid-burst, mid-refresh or mid-precharge SHALL abort the operation. The first legal command after deassertion is any ACT or REF.

Configuration
REQ-017 Macro DRAM_RESP_CHECK_EN:
- Defined: error detection and err/err_code per REQ-011/REQ-012.
- Undefined: err and err_code are tied 0 and the error logic is not compiled. Illegal commands are still ignored per REQ-011.

Verification
REQ-018 ACT bg0/bank1 row 0x123 at t=0, RD col 0x10 at t=4 -> rd_en_dq high t=9..12; dq_bank=1, dq_row=0x123, dq_col 0x10..0x13.
REQ-019 ACT at t=0, RD at t=3 -> err=1 at t=4, err_code=2, rd_en_dq never asserts; RD at t=4 -> accepted.
REQ-020 WR at t=10 to an ACTIVE bank, RD at t=12 -> wr_en_dq high t=14..17, err_code=5. RD at t=18 -> rd_en_dq high t=23..26.
REQ-021 All banks IDLE, REF at t=0 -> busy high t=1..15; ACT at t=8 gives err_code=6; ACT at t=16 accepted.
REQ-022 Two banks ACTIVE, PREA at t=0 -> bank_open clears, bank IDLE at t=4. REF at t=3 gives err_code=4.
REQ-023 nRST pulsed at t=11 during the REQ-018 burst -> all outputs 0 immediately; no further beats after deassertion.
